mod_n_updown_counter: RTL and testbench
=======================================

Name: mod_n_updown_counter

Overview:
- Parametrised synchronous up/down counter with programmable modulus.
- Replaces the fixed 4-bit ripple up-counter style in new logic.
- All state bits change on the same clk edge, so outputs are glitch-free and safe to sample or decode.
- Adds enable, direction, synchronous clear and load, wrap detection, and a cascade carry for chaining counters into wider or mixed-radix chains (BCD digits, timers).

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2**WIDTH; elaboration error if outside.
- RESET_VALUE, 0, value of q on rst; must be < MODULUS; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per clk edge while high.
- up_dn  input  1  1 = count up, 0 = count down; sampled only when a count step occurs.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count, registered.
- carry_out  output  1  combinational: en & ~clr & ~load & terminal-in-current-direction; drives the next stage's en.
- wrapped  output  1  registered sticky flag; set on any wrap, cleared by clr or rst.
- load_err  output  1  registered; one-cycle pulse when a load was rejected.

Behaviour:
- Reset (rst=1, asynchronous, immediate regardless of clk):
  - q = RESET_VALUE, wrapped = 0, load_err = 0.
  - Deassertion is synchronous to clk, handled externally. The first count occurs on the first posedge clk with rst=0.
- Priority per posedge clk, highest first: clr > load > en. Exactly one action per edge.
- clr=1:
  - q <= 0, wrapped <= 0, load_err <= 0.
  - load and en are ignored that cycle.
- load=1 (clr=0):
  - If load_val < MODULUS: q <= load_val, load_err <= 0.
  - Otherwise: q unchanged, load_err <= 1 for one cycle.
  - No count step occurs that cycle; wrapped is unchanged.
- en=1 (clr=0, load=0):
  - up_dn=1: q <= (q == MODULUS-1) ? 0 : q+1.
  - up_dn=0: q <= (q == 0) ? MODULUS-1 : q-1.
  - wrapped <= 1 on either wrap transition; otherwise it holds.
- en=0 with no clr or load: q holds.
- load_err deasserts on every edge where a rejected load is not present.
- Latency: q reflects an action one clk edge after the inputs are sampled. Count-step latency is 1 cycle.
- carry_out:
  - Combinational from registered q plus the en, up_dn, clr and load inputs.
  - High in the cycle before the wrap edge: q == MODULUS-1 with up_dn=1, or q == 0 with up_dn=0, and en=1, clr=0, load=0.
  - Chained stages clocked on the same clk therefore step on the same edge the lower stage wraps.
- Direction change mid-count: takes effect on the next step, with no skipped or repeated value. Example: q=5, up then down gives 6 then 5.
- MODULUS = 2**WIDTH: the wrap compare is equivalent to natural binary overflow; behaviour is identical.
- Arithmetic:
  - Internal compare and increment use WIDTH bits.
  - The MODULUS-1 constant is computed at elaboration and truncated only where provably fits.
  - No sign handling.
- X-safety: with rst asserted, all outputs are known irrespective of other inputs.

Test Plan:
- WIDTH=4, MODULUS=10, RESET_VALUE=0; rst pulse mid-cycle (not aligned to clk) -> q=0, wrapped=0, load_err=0 immediately, before the next edge.
- en=1, up_dn=1 for 12 cycles from 0:
  - q sequence 1..9, 0, 1, 2.
  - carry_out high only in the cycle q=9.
  - wrapped=1 from the cycle after q goes 9->0.
- up_dn=0 from q=2 for 4 cycles: q = 1, 0, 9, 8; carry_out high only while q=0.
- Loads:
  - load=1, load_val=7 -> q=7 next cycle.
  - load_val=12 -> q stays 7, load_err=1 for exactly one cycle.
  - clr=1, load=1, en=1 together -> q=0, wrapped=0.
- Cascade two instances (MODULUS=10) with low.carry_out -> high.en; count 0..99 from both 0 -> high steps exactly when low goes 9->0; after 100 steps both = 0 and both wrapped=1.
- WIDTH=3, MODULUS=8, RESET_VALUE=5:
  - rst -> q=5.
  - up from 7 -> 0 with wrapped=1.
  - en=0 for 5 cycles -> q holds.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// Synchronous modulo-N up/down counter with enable, clear, checked load,
// sticky wrap flag and a cascade carry for chaining stages on one clock.
module mod_n_updown_counter #(
    parameter int              WIDTH       = 4,
    parameter longint unsigned MODULUS     = 16,
    parameter longint unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             carry_out,
    output logic             wrapped,
    output logic             load_err
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("mod_n_updown_counter: WIDTH must be in 2..32");
        end
        if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
            $error("mod_n_updown_counter: MODULUS must be in 2..2**WIDTH");
        end
        if (RESET_VALUE >= MODULUS) begin : g_bad_reset
            $error("mod_n_updown_counter: RESET_VALUE must be below MODULUS");
        end
    endgenerate

    // MODULUS may equal 2**WIDTH, so the load bound needs one extra bit;
    // MODULUS-1 always fits in WIDTH bits.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrapped_q, wrapped_d;
    logic             load_err_q, load_err_d;
    logic             at_max, at_zero, load_ok;

    assign at_max  = (q_q == MAX_Q);
    assign at_zero = (q_q == '0);
    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    always_comb begin
        q_d        = q_q;
        wrapped_d  = wrapped_q;
        load_err_d = 1'b0;
        if (clr) begin
            q_d       = '0;
            wrapped_d = 1'b0;
        end else if (load) begin
            if (load_ok) begin
                q_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    q_d       = '0;
                    wrapped_d = 1'b1;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    q_d       = MAX_Q;
                    wrapped_d = 1'b1;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking here would chain them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= RST_Q;
            wrapped_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            wrapped_q  <= wrapped_d;
            load_err_q <= load_err_d;
        end
    end

    // High in the cycle before a wrap, so a chained stage steps on that edge.
    assign carry_out = en & ~clr & ~load & (up_dn ? at_max : at_zero);

    assign q        = q_q;
    assign wrapped  = wrapped_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench: the driver queues hand-computed expectations per cycle and
// a monitor checks carry mid-cycle and the registered outputs after the edge.
module tb_mod_n_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: WIDTH=4, MODULUS=10
    logic       d0_rst, d0_en, d0_up, d0_clr, d0_load;
    logic [3:0] d0_lv, d0_q;
    logic       d0_c, d0_wr, d0_le;
    // Cascade pair
    logic       c_rst, c_en;
    logic [3:0] lo_q, hi_q;
    logic       lo_c, hi_c, lo_wr, hi_wr, lo_le, hi_le;
    // WIDTH=3, MODULUS=8, RESET_VALUE=5
    logic       d2_rst, d2_en, d2_up, d2_clr, d2_load;
    logic [2:0] d2_lv, d2_q;
    logic       d2_c, d2_wr, d2_le;

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_dut (
        .clk(clk), .rst(d0_rst), .en(d0_en), .up_dn(d0_up), .clr(d0_clr),
        .load(d0_load), .load_val(d0_lv), .q(d0_q), .carry_out(d0_c),
        .wrapped(d0_wr), .load_err(d0_le));

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .up_dn(1'b1), .clr(1'b0),
        .load(1'b0), .load_val(4'd0), .q(lo_q), .carry_out(lo_c),
        .wrapped(lo_wr), .load_err(lo_le));

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_c), .up_dn(1'b1), .clr(1'b0),
        .load(1'b0), .load_val(4'd0), .q(hi_q), .carry_out(hi_c),
        .wrapped(hi_wr), .load_err(hi_le));

    mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(5)) u_d2 (
        .clk(clk), .rst(d2_rst), .en(d2_en), .up_dn(d2_up), .clr(d2_clr),
        .load(d2_load), .load_val(d2_lv), .q(d2_q), .carry_out(d2_c),
        .wrapped(d2_wr), .load_err(d2_le));

    typedef struct {
        int         sel;
        logic       ec;
        logic [7:0] eq;
        logic [1:0] ew;
        logic       el;
        string      nm;
    } rec_t;

    rec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_all();
        d0_en = 0; d0_up = 0; d0_clr = 0; d0_load = 0; d0_lv = '0;
        c_en  = 0;
        d2_en = 0; d2_up = 0; d2_clr = 0; d2_load = 0; d2_lv = '0;
    endtask

    // Apply one cycle of stimulus and queue what must be seen: carry during
    // this cycle, q/wrapped/load_err after the edge that ends it.
    task automatic drive(input int sel, input logic e, input logic u, input logic cl,
                         input logic ld, input logic [3:0] lv, input logic ec,
                         input logic [7:0] eq, input logic [1:0] ew, input logic el,
                         input string nm);
        rec_t r;
        @(posedge clk);
        #2;
        idle_all();
        case (sel)
            0: begin d0_en = e; d0_up = u; d0_clr = cl; d0_load = ld; d0_lv = lv; end
            1: c_en = e;
            default: begin d2_en = e; d2_up = u; d2_clr = cl; d2_load = ld; d2_lv = lv[2:0]; end
        endcase
        r.sel = sel; r.ec = ec; r.eq = eq; r.ew = ew; r.el = el; r.nm = nm;
        sb.push_back(r);
    endtask

    // Stop stimulus after exactly one edge, then wait for the monitor to finish.
    task automatic drain();
        int guard;
        @(posedge clk);
        #2;
        idle_all();
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        rec_t       r;
        logic       ac, al;
        logic [7:0] aq;
        logic [1:0] aw;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                r  = sb.pop_front();
                ac = (r.sel == 0) ? d0_c : (r.sel == 1) ? lo_c : d2_c;
                check({r.nm, "_carry"}, 32'(ac), 32'(r.ec));
                @(posedge clk);
                #1;
                case (r.sel)
                    0: begin aq = {4'b0, d0_q}; aw = {1'b0, d0_wr}; al = d0_le; end
                    1: begin aq = {hi_q, lo_q}; aw = {hi_wr, lo_wr}; al = lo_le | hi_le; end
                    default: begin aq = {5'b0, d2_q}; aw = {1'b0, d2_wr}; al = d2_le; end
                endcase
                check({r.nm, "_q"}, 32'(aq), 32'(r.eq));
                check({r.nm, "_wrapped"}, 32'(aw), 32'(r.ew));
                check({r.nm, "_load_err"}, 32'(al), 32'(r.el));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        idle_all();
        d0_rst = 1; c_rst = 1; d2_rst = 1;
        #3;
        check("rst_d0_q", 32'(d0_q), 0);
        check("rst_d0_wrapped", 32'(d0_wr), 0);
        check("rst_d2_q", 32'(d2_q), 5);
        #9;
        d0_rst = 0; c_rst = 0; d2_rst = 0;

        // Count up 12 cycles from 0 (MODULUS=10)
        drive(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, "up0");
        drive(0, 1, 1, 0, 0, 0, 0, 2, 0, 0, "up1");
        drive(0, 1, 1, 0, 0, 0, 0, 3, 0, 0, "up2");
        drive(0, 1, 1, 0, 0, 0, 0, 4, 0, 0, "up3");
        drive(0, 1, 1, 0, 0, 0, 0, 5, 0, 0, "up4");
        drive(0, 1, 1, 0, 0, 0, 0, 6, 0, 0, "up5");
        drive(0, 1, 1, 0, 0, 0, 0, 7, 0, 0, "up6");
        drive(0, 1, 1, 0, 0, 0, 0, 8, 0, 0, "up7");
        drive(0, 1, 1, 0, 0, 0, 0, 9, 0, 0, "up8");
        drive(0, 1, 1, 0, 0, 0, 1, 0, 1, 0, "up9_wrap");
        drive(0, 1, 1, 0, 0, 0, 0, 1, 1, 0, "up10");
        drive(0, 1, 1, 0, 0, 0, 0, 2, 1, 0, "up11");
        // Count down from 2
        drive(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, "dn0");
        drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "dn1");
        drive(0, 1, 0, 0, 0, 0, 1, 9, 1, 0, "dn2_wrap");
        drive(0, 1, 0, 0, 0, 0, 0, 8, 1, 0, "dn3");
        // Direction change, loads, holds, clear priority
        drive(0, 1, 1, 0, 0, 0, 0, 9, 1, 0, "dir_up");
        drive(0, 1, 0, 0, 0, 0, 0, 8, 1, 0, "dir_dn");
        drive(0, 0, 0, 0, 1, 7, 0, 7, 1, 0, "load7");
        drive(0, 1, 1, 0, 1, 12, 0, 7, 1, 1, "load12_rej");
        drive(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, "err_pulse_end");
        drive(0, 0, 0, 0, 1, 10, 0, 7, 1, 1, "load10_rej");
        drive(0, 0, 0, 0, 1, 9, 0, 9, 1, 0, "load9");
        drive(0, 0, 1, 0, 0, 0, 0, 9, 1, 0, "hold_at_max");
        drive(0, 1, 1, 1, 1, 3, 0, 0, 0, 0, "clr_prio");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "hold_zero");
        drive(0, 1, 0, 0, 0, 0, 1, 9, 1, 0, "dn_wrap_again");
        drive(0, 1, 1, 0, 1, 2, 0, 2, 1, 0, "load_blocks_carry");
        drain();

        // Asynchronous reset pulse between edges, then first count after release
        @(negedge clk);
        #1 d0_rst = 1;
        #1;
        check("async_rst_q", 32'(d0_q), 0);
        check("async_rst_wrapped", 32'(d0_wr), 0);
        check("async_rst_load_err", 32'(d0_le), 0);
        #1 d0_rst = 0;
        drive(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, "first_count");
        drain();

        // Cascade: 100 steps, hi steps when lo wraps 9->0
        for (int i = 0; i < 100; i++) begin
            drive(1, 1, 1, 0, 0, 0, 1'((i % 10) == 9),
                  {4'((i + 1) / 10 % 10), 4'((i + 1) % 10)},
                  {1'(i >= 99), 1'(i >= 9)}, 0, $sformatf("casc%0d", i));
        end
        drain();

        // WIDTH=3 MODULUS=8 RESET_VALUE=5
        drive(2, 0, 0, 0, 1, 2, 0, 2, 0, 0, "w3_load2");
        drain();
        @(negedge clk);
        #1 d2_rst = 1;
        #1;
        check("w3_rst_q", 32'(d2_q), 5);
        #1 d2_rst = 0;
        drive(2, 0, 0, 0, 1, 7, 0, 7, 0, 0, "w3_load7");
        drive(2, 1, 1, 0, 0, 0, 1, 0, 1, 0, "w3_wrap");
        drive(2, 1, 1, 0, 0, 0, 0, 1, 1, 0, "w3_up1");
        for (int i = 0; i < 5; i++) begin
            drive(2, 0, 1, 0, 0, 0, 0, 1, 1, 0, $sformatf("w3_hold%0d", i));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
